// File: rtl/raid_pkg.sv
// Shared RAID5 controller types: sequencer states, sweep modes
// and the default geometry also used by the disk controller.
package raid_pkg;

    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_NUM_DISKS = 4;

    localparam logic MODE_CLEAR   = 1'b0;
    localparam logic MODE_RESTORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/raid_block_sequencer_if.sv
// Operation channel from the block sequencer to the per-disk
// access controller (valid/ready handshake plus payload).
interface raid_block_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DISK_W = 2
);
    logic              op_valid;
    logic              op_ready;
    logic [ADDR_W-1:0] op_block;
    logic [DISK_W-1:0] op_disk;
    logic              op_wr;
    logic [DISK_W-1:0] parity_disk;

    modport master (
        output op_valid, op_block, op_disk, op_wr, parity_disk,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_block, op_disk, op_wr, parity_disk,
        output op_ready
    );
endinterface

// File: rtl/raid_block_sequencer_disk_cursor.sv
// Per-block disk walker: ordered disk index with failed-disk skip,
// RESTORE write phase, last-op flag and rotating parity counter.
module disk_cursor
    import raid_pkg::*;
#(
    parameter int NUM_DISKS = DEF_NUM_DISKS,
    parameter int DISK_W    = $clog2(NUM_DISKS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load,
    input  logic              adv,
    input  logic              mode,
    input  logic [DISK_W-1:0] fail_disk,
    input  logic [DISK_W-1:0] parity_init,
    output logic [DISK_W-1:0] disk,
    output logic [DISK_W-1:0] parity,
    output logic              wr,
    output logic              last_op
);

    logic              mode_q, mode_d;
    logic              wr_q, wr_d;
    logic [DISK_W-1:0] fail_q, fail_d;
    logic [DISK_W-1:0] disk_q, disk_d;
    logic [DISK_W-1:0] par_q, par_d;
    logic [DISK_W-1:0] first;
    logic [DISK_W:0]   cand;

    // Next read candidate, stepping over the disk being rebuilt
    always_comb begin
        first = '0;
        if (mode_q == MODE_RESTORE && fail_q == '0) begin
            first = DISK_W'(1);
        end
        cand = {1'b0, disk_q} + (DISK_W+1)'(1);
        if (cand == {1'b0, fail_q}) begin
            cand = cand + (DISK_W+1)'(1);
        end
        if (mode_q == MODE_RESTORE) begin
            last_op = wr_q;
        end else begin
            last_op = (disk_q == DISK_W'(NUM_DISKS - 1));
        end
    end

    always_comb begin
        mode_d = mode_q;
        fail_d = fail_q;
        disk_d = disk_q;
        par_d  = par_q;
        wr_d   = wr_q;
        if (load) begin
            mode_d = mode;
            fail_d = fail_disk;
            wr_d   = (mode == MODE_CLEAR);
            disk_d = '0;
            if (mode == MODE_RESTORE && fail_disk == '0) begin
                disk_d = DISK_W'(1);
            end
            par_d = parity_init;
        end else if (adv) begin
            if (last_op) begin
                disk_d = first;
                wr_d   = (mode_q == MODE_CLEAR);
                if (par_q == '0) begin
                    par_d = DISK_W'(NUM_DISKS - 1);
                end else begin
                    par_d = par_q - DISK_W'(1);
                end
            end else if (mode_q == MODE_CLEAR) begin
                disk_d = disk_q + DISK_W'(1);
            end else if (cand < (DISK_W+1)'(NUM_DISKS)) begin
                disk_d = cand[DISK_W-1:0];
            end else begin
                disk_d = fail_q;
                wr_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q <= MODE_CLEAR;
            fail_q <= '0;
            disk_q <= '0;
            par_q  <= '0;
            wr_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            fail_q <= fail_d;
            disk_q <= disk_d;
            par_q  <= par_d;
            wr_q   <= wr_d;
        end
    end

    assign disk   = disk_q;
    assign parity = par_q;
    assign wr     = wr_q;

endmodule

// File: rtl/raid_block_sequencer.sv
// Clear/restore sweep sequencer: walks blocks start..last and
// issues one disk operation per handshake on the op channel.
module raid_block_sequencer
    import raid_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_DISKS = DEF_NUM_DISKS,
    parameter int DISK_W    = $clog2(NUM_DISKS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] start_block,
    input  logic [ADDR_W-1:0] last_block,
    input  logic [DISK_W-1:0] fail_disk,
    raid_block_sequencer_if.master op,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              range_err
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] block_q, block_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              abt_q, abt_d;
    logic              rng_q, rng_d;
    logic              load, adv, last_op;
    logic [DISK_W-1:0] parity_init;

    // Parity sits on the highest disk for block 0 and rotates down
    assign parity_init = DISK_W'(ADDR_W'(NUM_DISKS - 1)
                         - (start_block % ADDR_W'(NUM_DISKS)));

    always_comb begin
        state_d = state_q;
        block_d = block_q;
        last_d  = last_q;
        abt_d   = abt_q;
        rng_d   = rng_q;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    abt_d = 1'b0;
                    if (start_block <= last_block) begin
                        state_d = RUN;
                        block_d = start_block;
                        last_d  = last_block;
                        rng_d   = 1'b0;
                        load    = 1'b1;
                    end else begin
                        state_d = FINISH;
                        rng_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                adv = op.op_ready;
                if (op.op_ready && last_op) begin
                    if (block_q == last_q) begin
                        state_d = FINISH;
                    end else begin
                        block_d = block_q + ADDR_W'(1);
                    end
                end
                if (abort) begin
                    state_d = FINISH;
                    abt_d   = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            block_q <= '0;
            last_q  <= '0;
            abt_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            last_q  <= last_d;
            abt_q   <= abt_d;
            rng_q   <= rng_d;
        end
    end

    disk_cursor #(
        .NUM_DISKS(NUM_DISKS),
        .DISK_W   (DISK_W)
    ) u_cursor (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (load),
        .adv        (adv),
        .mode       (mode),
        .fail_disk  (fail_disk),
        .parity_init(parity_init),
        .disk       (op.op_disk),
        .parity     (op.parity_disk),
        .wr         (op.op_wr),
        .last_op    (last_op)
    );

    assign op.op_valid = (state_q == RUN);
    assign op.op_block = block_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == FINISH);
    assign aborted     = done & abt_q;
    assign range_err   = done & rng_q;

endmodule

// File: tb/tb_raid_block_sequencer.sv
// Self-checking bench for raid_block_sequencer (11-bit, 4 disks).
module tb_raid_block_sequencer;

    localparam int AW = 11;
    localparam int ND = 4;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] start_block = '0;
    logic [AW-1:0] last_block = '0;
    logic [DW-1:0] fail_disk = '0;
    logic          busy, done, aborted, range_err;

    int errors = 0;
    int checks = 0;

    raid_block_sequencer_if #(.ADDR_W(AW), .DISK_W(DW)) bus ();

    raid_block_sequencer #(
        .ADDR_W   (AW),
        .NUM_DISKS(ND)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .start_block(start_block),
        .last_block (last_block),
        .fail_disk  (fail_disk),
        .op         (bus),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] blk;
        logic [DW-1:0] d;
        logic          wr;
        logic [DW-1:0] par;
    } op_t;

    typedef struct {
        bit mode;
        int fail;
        int sb;
        int lb;
        int rdy;
        int ab;
        bit gl;
        int n_ops;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] cur_op();
        return {bus.op_block, bus.op_disk, bus.op_wr, bus.parity_disk};
    endfunction

    // Reference: expected operation list of a whole sweep
    task automatic build_model(input bit md, input int fl, input int sb,
                               input int lb, output op_t q[$]);
        op_t e;
        q = {};
        for (int b = sb; b <= lb; b++) begin
            e.blk = AW'(b);
            e.par = DW'(ND - 1 - (b % ND));
            for (int d = 0; d < ND; d++) begin
                if (md == 1'b0) begin
                    e.d = DW'(d); e.wr = 1'b1; q.push_back(e);
                end else if (d != fl) begin
                    e.d = DW'(d); e.wr = 1'b0; q.push_back(e);
                end
            end
            if (md == 1'b1) begin
                e.d = DW'(fl); e.wr = 1'b1; q.push_back(e);
            end
        end
    endtask

    task automatic run_sweep(input bit md, input int fl, input int sb,
                             input int lb, input int rdy, input int ab,
                             input bit gl, output int nhs);
        op_t q[$];
        op_t e;
        int last_hs, bound;
        bit rng, fin, prev_stall;
        logic [15:0] sv;
        rng = (sb > lb);
        build_model(md, fl, sb, lb, q);
        mode = md;
        fail_disk = DW'(fl);
        start_block = AW'(sb);
        last_block = AW'(lb);
        start = 1'b1;
        bus.op_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nhs = 0;
        last_hs = -1;
        fin = 1'b0;
        prev_stall = 1'b0;
        sv = '0;
        bound = q.size() * 4 + 20;
        for (int cyc = 0; cyc < bound && !fin; cyc++) begin
            abort = 1'b0;
            start = 1'b0;
            if (done) begin
                fin = 1'b1;
                chk("done_latency", cyc, last_hs + 1);
                chk("done_busy", busy, 1'b0);
                chk("done_valid", bus.op_valid, 1'b0);
                chk("aborted", aborted, ab != 0);
                chk("range_err", range_err, rng);
                if (ab == 0) chk("ops_left", q.size(), 0);
            end else begin
                chk("valid", bus.op_valid, 1'b1);
                chk("busy", busy, 1'b1);
                if (prev_stall) chk("stall_hold", cur_op(), sv);
                case (rdy)
                    0: bus.op_ready = 1'b1;
                    1: bus.op_ready = (cyc % 2 == 0);
                    default: bus.op_ready = 1'($urandom_range(0, 1));
                endcase
                if (gl && cyc == 2) begin
                    start = 1'b1;
                    mode = ~md;
                    start_block = '0;
                    last_block = '1;
                end
                if (bus.op_valid && bus.op_ready) begin
                    if (q.size() == 0) begin
                        chk("extra_op", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("op", cur_op(), {e.blk, e.d, e.wr, e.par});
                    end
                    nhs++;
                    last_hs = cyc;
                    if (nhs == ab) abort = 1'b1;
                end
                prev_stall = bus.op_valid && !bus.op_ready;
                sv = cur_op();
            end
            @(negedge clk);
        end
        if (!fin) chk("done_timeout", 0, 1);
        abort = 1'b0;
        start = 1'b0;
        bus.op_ready = 1'b0;
        chk("done_pulse_len", done, 1'b0);
        chk("post_valid", bus.op_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        @(negedge clk);
        chk("no_resweep", {bus.op_valid, busy, done}, 3'b000);
    endtask

    vec_t vecs[$];
    int nhs;

    initial begin
        vecs = '{
            '{0, 0,    5,    6, 0, 0, 0,  8},
            '{1, 2,    0,    0, 1, 0, 0,  4},
            '{0, 0, 2047, 2047, 0, 0, 0,  4},
            '{0, 0,   20,   29, 0, 3, 0,  3},
            '{0, 0,    9,    4, 0, 0, 0,  0},
            '{0, 0,   40,   45, 0, 0, 1, 24},
            '{1, 0,    7,    8, 2, 0, 0,  8},
            '{1, 3, 2045, 2047, 1, 0, 0, 12},
            '{1, 1,   12,   12, 0, 2, 0,  2}
        };
        bus.op_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs",
            {bus.op_valid, bus.op_block, bus.op_disk, bus.op_wr,
             bus.parity_disk, busy, done, aborted, range_err}, 0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", {bus.op_valid, busy, done}, 3'b000);

        foreach (vecs[i]) begin
            run_sweep(vecs[i].mode, vecs[i].fail, vecs[i].sb,
                      vecs[i].lb, vecs[i].rdy, vecs[i].ab,
                      vecs[i].gl, nhs);
            chk($sformatf("vec%0d_ops", i), nhs, vecs[i].n_ops);
        end

        for (int r = 0; r < 25; r++) begin
            bit md;
            int fl, sb, lb, exp_n;
            md = 1'($urandom_range(0, 1));
            fl = $urandom_range(0, ND - 1);
            sb = $urandom_range(0, 2047);
            lb = sb + $urandom_range(0, 3);
            if (lb > 2047) lb = 2047;
            if ($urandom_range(0, 7) == 0 && sb > 0) lb = sb - 1;
            exp_n = (lb < sb) ? 0 : (lb - sb + 1) * ND;
            run_sweep(md, fl, sb, lb, 2, 0, 0, nhs);
            chk($sformatf("rand%0d_ops", r), nhs, exp_n);
        end

        // Asynchronous reset in the middle of a sweep
        mode = 1'b0;
        start_block = AW'(100);
        last_block = AW'(110);
        start = 1'b1;
        bus.op_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        chk("rst_outs",
            {bus.op_valid, bus.op_block, bus.op_disk, bus.op_wr,
             bus.parity_disk, busy, done, aborted, range_err}, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_done", {done, bus.op_valid}, 2'b00);
        end
        n_rst = 1'b1;
        bus.op_ready = 1'b0;
        @(negedge clk);
        chk("after_rst_idle", {done, busy, bus.op_valid}, 3'b000);
        run_sweep(1'b0, 0, 3, 3, 0, 0, 0, nhs);
        chk("after_rst_ops", nhs, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/raid_block_sequencer.md
# raid_block_sequencer

Parametrised block/disk operation sequencer for the RAID5 controller's clear-disk and restore-disk flows. It replaces the fixed 11-bit, fixed-2000 block counter. Given a start/last block range, it walks every block and, within each block, every member disk, issuing one valid/ready operation per step. Each operation carries the block number, the target disk, a read/write flag and the rotating parity disk. It sits between the host command decoder and the per-disk access controller.

## Interface
- ADDR_W, 11, block-number width
- NUM_DISKS, 4, member disks; legal range 3..8
- DISK_W, $clog2(NUM_DISKS), disk-index width (derived)
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  stop the current sweep; sampled only in RUN
- mode  in  1  0 = CLEAR, 1 = RESTORE
- start_block  in  ADDR_W  first block; latched on accepted start
- last_block  in  ADDR_W  final block, inclusive; latched on accepted start
- fail_disk  in  DISK_W  disk being rebuilt; RESTORE only; latched on accepted start
- op_ready  in  1  downstream accepts the current operation
- op_valid  out  1  operation presented
- op_block  out  ADDR_W  block of the current operation
- op_disk  out  DISK_W  disk of the current operation
- op_wr  out  1  1 = write, 0 = read
- parity_disk  out  DISK_W  parity disk for op_block
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at sweep end
- aborted  out  1  valid with done; sweep ended by abort
- range_err  out  1  valid with done; last_block < start_block

## Operation
- **States:** IDLE, RUN, FINISH.
- **IDLE → RUN:** start=1 and start_block ≤ last_block. Latch start_block, last_block, mode and fail_disk. Set block = start_block.
  - Disk cursor = 0. In RESTORE with fail_disk = 0, the cursor starts at 1 instead.
  - parity_disk = NUM_DISKS−1−(start_block % NUM_DISKS).
- **IDLE → FINISH:** start=1 and start_block > last_block. Sets range_err=1 and issues no operations.
- **CLEAR mode:** per block, disks 0..NUM_DISKS−1 in order; every operation has op_wr=1.
- **RESTORE mode:** per block:
  - Reads (op_wr=0) on every disk except fail_disk, in ascending order.
  - Then one write (op_wr=1) on fail_disk.
- **Advance:** only on a handshake (op_valid & op_ready).
  - After the block's final operation, if block == last_block, go to FINISH.
  - Otherwise increment block and reset the disk cursor.
  - parity_disk decrements, wrapping from 0 to NUM_DISKS−1. No runtime modulo is used.
- **Wrap-around:** the end test is equality, checked before increment. last_block = 2^ADDR_W−1 must therefore terminate without wrapping to 0.
- **abort in RUN:** go to FINISH with aborted=1.
  - If a handshake occurs in the same cycle, that operation counts as accepted.
  - op_valid drops on the next cycle.
- **FINISH:** done=1 for one cycle, then return to IDLE. aborted and range_err are valid only while done=1 and read 0 otherwise.
- **Ignored inputs:** start while not in IDLE; abort outside RUN.
- **Reset:** asynchronous, from any state, including mid-sweep. State goes to IDLE; all outputs are 0; no done pulse is produced.

## Timing
- start accepted at edge N: op_valid=1 from cycle N+1 with the first operation.
- op_valid, op_block, op_disk, op_wr and parity_disk are registered. They hold stable while op_valid & !op_ready.
- Back-to-back throughput is one operation per cycle when op_ready is held high.
- Ops per block: CLEAR issues NUM_DISKS operations; RESTORE issues NUM_DISKS (NUM_DISKS−1 reads + 1 write).
- Last handshake at edge M: done=1 in cycle M+1 and op_valid=0 in that cycle. start is accepted again from cycle M+2.
- abort at edge A: done=1 in cycle A+1.
- busy = (state==RUN); it is deasserted in the same cycle done rises.

## Structure
- **Shared package `raid_pkg`:**
  - State enum `seq_state_t` (IDLE, RUN, FINISH).
  - Mode constants MODE_CLEAR=1'b0 and MODE_RESTORE=1'b1.
  - Default ADDR_W and NUM_DISKS localparams, shared with the disk controller.
- **Sub-module `disk_cursor`:** a natural split. It is the per-block disk walker: skip-index, wrap, last-op flag and parity down-counter. The top level keeps the FSM and the block register.
- The old fixed counter instance is not reused.

## Test plan
All scenarios use ADDR_W=11, NUM_DISKS=4.
1. **CLEAR sweep:** CLEAR, start=5, last=6, op_ready=1.
   - Required: 8 ops (5/0..3 then 6/0..3), all op_wr=1.
   - parity_disk is 2 for block 5 and 1 for block 6.
   - done exactly one cycle after the 8th handshake; busy low thereafter.
2. **RESTORE with backpressure:** RESTORE, fail_disk=2, block 0 only, op_ready toggling 1/0.
   - Required sequence: rd d0, rd d1, rd d3, wr d2.
   - Outputs stay stable during stalls.
3. **Top-of-range end:** CLEAR, start=last=2047.
   - Required: 4 ops, then done.
   - op_block never becomes 0; no second sweep.
4. **Abort with handshake:** abort asserted on the same cycle as the 3rd handshake of a 10-block sweep.
   - Required: exactly 3 ops accepted; done=1 and aborted=1 on the next cycle; op_valid=0.
5. **Range error:** start with start_block=9, last_block=4.
   - Required: no op_valid; done=1 with range_err=1 at cycle N+1.
   - A start pulse while busy is ignored.
6. **Reset mid-sweep:** drive n_rst low asynchronously during RUN between edges.
   - Required: all outputs 0 immediately; no done pulse.
   - After release, a new start runs normally.
